eth_reset_req: RTL
==================

ETH_RESET_REQ -- requirements
Module: eth_reset_req

Interface
REQ-001 Parameter min_cycles_p, default 8: minimum cycles async_reset_o stays high after the far-domain acknowledge is seen; legal range 1..255.
REQ-002 Parameter timeout_p, default 1024: cycle limit for each acknowledge wait; used only when ETH_RESET_REQ_TIMEOUT_EN is defined.
REQ-003 clk_i  input  1  the single clock; all logic is on the rising edge.
REQ-004 reset_i  input  1  reset; synchronous, active-high.
REQ-005 req_i  input  1  single-cycle request to reset the far clock domain.
REQ-006 ack_async_i  input  1  far-domain synchronized reset output (high while far side is held in reset); asynchronous to clk_i.
REQ-007 async_reset_o  output  1  registered reset driven into the far domain's asynchronous-assert reset synchronizer.
REQ-008 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-009 done_o  output  1  one-cycle pulse when a sequence completes.
REQ-010 error_o  output  1  sticky timeout flag.

Function
REQ-011 The block SHALL double-flop ack_async_i into ack_s before any use; ack_s lags ack_async_i by 2 cycles.
REQ-012 The FSM SHALL have states IDLE, ASSERT, HOLD, RELEASE, DONE.
REQ-013 IDLE: async_reset_o=0; on req_i=1, go to ASSERT next cycle.
REQ-014 ASSERT: async_reset_o=1; on ack_s=1, clear the hold counter and go to HOLD.
REQ-015 HOLD: async_reset_o=1; the counter increments each cycle; when it reaches min_cycles_p-1, go to RELEASE.
REQ-016 RELEASE: async_reset_o=0; on ack_s=0, go to DONE.
REQ-017 DONE: done_o=1 for exactly this cycle; next state is IDLE.
REQ-018 async_reset_o SHALL be a flop output; it is glitch-free and changes only on clock edges.
REQ-019 req_i outside IDLE SHALL be ignored and not queued.
REQ-020 Counter width SHALL be 8 bits, with no wrap inside HOLD.
REQ-021 An ack_s glitch back to 0 during HOLD SHALL NOT abort or restart the hold.
REQ-022 Minimum async_reset_o high time SHALL be min_cycles_p cycles plus the acknowledge wait.

Reset
REQ-023 When reset_i=1, the FSM SHALL enter ASSERT, with async_reset_o=1, busy_o=1, done_o=0, error_o=0, counter=0 and both sync flops=1.
REQ-024 After reset_i is released, the full ASSERT->HOLD->RELEASE->DONE sequence SHALL run without any req_i, so the far domain always comes out of reset after the near domain.
REQ-025 reset_i mid-sequence SHALL restart the sequence from ASSERT; no done_o pulse is produced for the aborted sequence.

Configuration
REQ-026 With ETH_RESET_REQ_TIMEOUT_EN defined: a wait counter counts cycles in ASSERT and in RELEASE, cleared on every state entry.
REQ-027 Timeout action: if the wait counter reaches timeout_p, set error_o=1, go to IDLE with async_reset_o=0, and produce no done_o.
REQ-028 error_o clears on reset_i or on the next accepted req_i.
REQ-029 Without ETH_RESET_REQ_TIMEOUT_EN: no wait counter exists, error_o is tied to 0, and the waits are unbounded.

Structure
REQ-030 Package eth_reset_pkg SHALL hold the state enum eth_reset_state_e and the constant eth_reset_cnt_width_gp=8.
REQ-031 The 2-flop synchronizer SHALL be sub-module eth_ack_sync, with reset value 1 and one instance.

Verification
REQ-032 reset_i high for 3 cycles, then low; far model returns ack 1 after 4 cycles and 0 after 4 cycles -> async_reset_o high from reset through HOLD (8 cycles), then low; one done_o pulse; error_o=0.
REQ-033 From IDLE, req_i pulse -> async_reset_o=1 next cycle; busy_o=1 until DONE; done_o exactly once.
REQ-034 Three req_i pulses during HOLD -> ignored; exactly one done_o.
REQ-035 min_cycles_p=1, ack returned immediately -> async_reset_o high time = 1 cycle + 2 sync cycles + the ASSERT cycle.
REQ-036 TIMEOUT_EN defined, timeout_p=16, ack held 0 -> after 16 cycles in ASSERT: error_o=1, async_reset_o=0, no done_o; a later req_i clears error_o.
REQ-037 reset_i pulsed during RELEASE -> async_reset_o=1 the next cycle; the sequence restarts; no done_o from the aborted run.

Source files
------------

// File: rtl/eth_reset_req_pkg.sv
// Shared state encoding and counter width for the far-domain reset requester.
package eth_reset_pkg;

  localparam int eth_reset_cnt_width_gp = 8;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE,
    DONE
  } eth_reset_state_e;

endpackage

// File: rtl/eth_reset_req_ack_sync.sv
// Two-flop synchronizer for the far-domain reset acknowledge; presets to 1 so a
// near-side reset looks like the far side is already held.
module eth_ack_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eth_reset_req.sv
// Drives a registered reset into a far clock domain, holds it min_cycles_p cycles past the acknowledge, then releases.
// Define ETH_RESET_REQ_TIMEOUT_EN to bound both acknowledge waits by timeout_p and flag a sticky error_o.
module eth_reset_req
  import eth_reset_pkg::*;
#(
  parameter int min_cycles_p = 8,
  parameter int timeout_p    = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,
  input  logic ack_async_i,
  output logic async_reset_o,
  output logic busy_o,
  output logic done_o,
  output logic error_o
);

  localparam logic [eth_reset_cnt_width_gp-1:0] hold_last_lp =
    eth_reset_cnt_width_gp'(min_cycles_p - 1);

  logic ack_s;
  logic timeout_hit;

  eth_reset_state_e                  state_q, state_d;
  logic [eth_reset_cnt_width_gp-1:0] cnt_q, cnt_d;
  logic                              async_reset_q, async_reset_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;

  eth_ack_sync u_ack_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (ack_async_i),
    .q_o    (ack_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = ASSERT;
      end
      ASSERT: begin
        if (ack_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // Acknowledge is deliberately ignored here: a late glitch must not shorten the hold.
        if (cnt_q == hold_last_lp) state_d = RELEASE;
        else                       cnt_d   = cnt_q + eth_reset_cnt_width_gp'(1);
      end
      RELEASE: begin
        if (!ack_s)           state_d = DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    async_reset_d = (state_d == ASSERT) || (state_d == HOLD);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
  end

`ifdef ETH_RESET_REQ_TIMEOUT_EN
  localparam int wait_w_lp = $clog2(timeout_p + 1);

  logic [wait_w_lp-1:0] wait_q, wait_d;
  logic                 error_q, error_d;

  assign timeout_hit = (state_q inside {ASSERT, RELEASE}) &&
                       (wait_q == wait_w_lp'(timeout_p - 1));

  always_comb begin
    wait_d  = wait_q;
    error_d = error_q;
    if (state_d != state_q)                 wait_d = '0;
    else if (state_q inside {ASSERT, RELEASE}) wait_d = wait_q + wait_w_lp'(1);
    if ((state_q == IDLE) && req_i)         error_d = 1'b0;
    if (timeout_hit && (state_d == IDLE))   error_d = 1'b1;
  end

  assign error_o = error_q;
`else
  logic unused_timeout;

  // Without the wait counter the waits are unbounded and timeout_p has no effect.
  assign timeout_hit    = 1'b0;
  assign unused_timeout = timeout_p[0];
  assign error_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ASSERT;
      cnt_q         <= '0;
      async_reset_q <= 1'b1;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
`ifdef ETH_RESET_REQ_TIMEOUT_EN
      wait_q        <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      async_reset_q <= async_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef ETH_RESET_REQ_TIMEOUT_EN
      wait_q        <= wait_d;
      error_q       <= error_d;
`endif
    end
  end

  assign async_reset_o = async_reset_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
